rr_grant_arbiter: RTL

Sequential round-robin arbiter with grant locking. It sits between N requesters and a shared resource, extending the combinational arbiter and priority-encoder blocks with registered state.
- Grants one requester at a time and holds the grant until the holder signals done or drops its request.
- Rotates priority so the requester just served has lowest priority next.
- Outputs a one-hot grant plus its binary index, both registered.

---
 rtl/rr_grant_arbiter_pkg.sv | 22 ++
 rtl/rr_pick.sv | 33 +++
 rtl/rr_grant_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rr_grant_arbiter_pkg.sv
// Shared definitions for the round-robin grant arbiter.
// The state encoding and default sizes live here.
// The wrap helper is used by the picker and the top level.
package rr_grant_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

   localparam int RR_DEF_N  = 8;
   localparam int RR_DEF_IW = 3;

   // Rotating scan position: (base + off) mod n, assuming base < n and off < n.
   function automatic int rr_wrap(input int base, input int off, input int n);
      int s;
      s = base + off;
      if (s >= n) s = s - n;
      return s;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority picker.
// It returns the first set bit of i_cand, scanning upward from i_start
// and wrapping from N-1 back to 0.
module rr_pick
   import rr_grant_arbiter_pkg::*;
#(
   parameter int N  = RR_DEF_N,
   parameter int IW = RR_DEF_IW
) (
   input  logic [N-1:0]  i_cand,
   input  logic [IW-1:0] i_start,
   output logic [N-1:0]  o_onehot,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   // Scan from the start pointer. The first candidate found wins.
   always_comb begin
      logic [IW-1:0] v_k;
      o_onehot = '0;
      o_idx    = '0;
      o_any    = 1'b0;
      for (int i = 0; i < N; i++) begin
         v_k = IW'(rr_wrap(int'(i_start), i, N));
         if (!o_any && i_cand[v_k]) begin
            o_any          = 1'b1;
            o_onehot[v_k]  = 1'b1;
            o_idx          = v_k;
         end
      end
   end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Sequential round-robin arbiter with grant locking.
// A grant is held until the holder asserts done or drops its request.
// Priority then rotates past the holder.
// Optional feature macro: ARB_TIMEOUT_EN. When it is defined, a grant is
// forcibly released after MAXHOLD cycles, and timeout pulses for one cycle.
module rr_grant_arbiter
   import rr_grant_arbiter_pkg::*;
#(
   parameter int N       = RR_DEF_N,
   parameter int IW      = RR_DEF_IW,
   parameter int MAXHOLD = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          done,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          grant_valid,
   output logic          timeout
);

   arb_state_t    r_state, w_state_next;
   logic [IW-1:0] r_ptr, w_ptr_next;
   logic [N-1:0]  r_grant, w_grant_next;
   logic [IW-1:0] r_idx, w_idx_next;
   logic          r_timeout, w_timeout_next;

   logic [N-1:0]  w_cand;
   logic [IW-1:0] w_start;
   logic [N-1:0]  w_pick_onehot;
   logic [IW-1:0] w_pick_idx;
   logic          w_pick_any;
   logic [IW-1:0] w_h_inc;
   logic          w_release;
   logic          w_force;
   logic          w_new_grant;

`ifdef ARB_TIMEOUT_EN
   localparam int HOLD_W = $clog2(MAXHOLD + 1);
   logic [HOLD_W-1:0] r_hold, w_hold_next;
`else
   logic w_unused_maxhold;
   assign w_unused_maxhold = (MAXHOLD > 0);
`endif

   rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .i_cand   (w_cand),
      .i_start  (w_start),
      .o_onehot (w_pick_onehot),
      .o_idx    (w_pick_idx),
      .o_any    (w_pick_any)
   );

   // Release detection and candidate selection for the picker.
   always_comb begin
      w_h_inc   = (r_idx == IW'(N - 1)) ? '0 : r_idx + 1'b1;
      w_release = (r_state == ST_BUSY) && (done || !req[r_idx]);
`ifdef ARB_TIMEOUT_EN
      w_force   = (r_state == ST_BUSY) && !w_release && (r_hold == HOLD_W'(MAXHOLD - 1));
`else
      w_force   = 1'b0;
`endif
      if (r_state == ST_IDLE) begin
         w_cand  = req;
         w_start = r_ptr;
      end else begin
         // The outgoing holder is excluded so that it cannot win again immediately.
         w_cand  = req & ~r_grant;
         w_start = w_h_inc;
      end
   end

   // Next-state and next-output logic. Defaults hold the current values.
   always_comb begin
      w_state_next   = r_state;
      w_ptr_next     = r_ptr;
      w_grant_next   = r_grant;
      w_idx_next     = r_idx;
      w_timeout_next = 1'b0;
      w_new_grant    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_pick_any) begin
               w_state_next = ST_BUSY;
               w_grant_next = w_pick_onehot;
               w_idx_next   = w_pick_idx;
               w_new_grant  = 1'b1;
            end
         end
         ST_BUSY: begin
            if (w_release || w_force) begin
               w_ptr_next     = w_h_inc;
               w_timeout_next = w_force;
               if (w_pick_any) begin
                  w_grant_next = w_pick_onehot;
                  w_idx_next   = w_pick_idx;
                  w_new_grant  = 1'b1;
               end else begin
                  w_state_next = ST_IDLE;
                  w_grant_next = '0;
                  w_idx_next   = '0;
               end
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_grant_next = '0;
            w_idx_next   = '0;
         end
      endcase
   end

   // State, pointer and grant registers. Reset clears the grant immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_ptr     <= '0;
         r_grant   <= '0;
         r_idx     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_ptr     <= w_ptr_next;
         r_grant   <= w_grant_next;
         r_idx     <= w_idx_next;
         r_timeout <= w_timeout_next;
      end
   end

`ifdef ARB_TIMEOUT_EN
   // Hold-time counter. It clears on every new grant and counts each held cycle.
   always_comb begin
      if (w_new_grant || w_state_next == ST_IDLE) begin
         w_hold_next = '0;
      end else if (r_state == ST_BUSY) begin
         w_hold_next = r_hold + 1'b1;
      end else begin
         w_hold_next = r_hold;
      end
   end

   // Hold-counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hold <= '0;
      end else begin
         r_hold <= w_hold_next;
      end
   end
`else
   logic w_unused_new_grant;
   assign w_unused_new_grant = w_new_grant;
`endif

   assign grant       = r_grant;
   assign grant_idx   = r_idx;
   assign grant_valid = (r_state == ST_BUSY);
   assign timeout     = r_timeout;

endmodule
